sprite_drawer: RTL and testbench

SPRITE_DRAWER -- requirements
Module: sprite_drawer

---
 rtl/sprite_drawer.sv | 216 +++++++++++++++++++++
 tb/tb_sprite_drawer.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_drawer.sv
// ----------------------------------------------------------------------------
// sprite_drawer
//
// Walks a rectangular sprite (the bird or a full-height wall) one pixel
// position per clock and presents each position to a VGA adapter. The sprite
// is scanned row-major: the column counter is the inner loop and the row
// counter is the outer loop.
//
// A wall covers every screen row, except for a vertical gap where plot stays
// low while the positions are still scanned. Any position that falls off the
// right or bottom edge of the screen is scanned but not plotted.
//
// Ports
//   clk           : system clock, all state changes on the rising edge
//   resetn        : asynchronous active-low reset
//   start         : draw request, only looked at while idle
//   obj_sel       : 0 = wall, 1 = bird (captured with start)
//   erase         : 1 = draw in the background colour (captured with start)
//   bird_y        : bird top row (captured with start)
//   wall_x        : wall left column (captured with start)
//   gap_y         : first row of the wall gap (captured with start)
//   x, y          : pixel column / row for the VGA adapter
//   colour        : pixel colour for the VGA adapter
//   plot          : write enable for x/y/colour in this cycle
//   busy          : high while a draw is in progress or completing
//   finished_draw : one-cycle pulse in the cycle after the last pixel
// ----------------------------------------------------------------------------
module sprite_drawer #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120,
  parameter int BIRD_X   = 20,
  parameter int BIRD_W   = 4,
  parameter int BIRD_H   = 4,
  parameter int WALL_W   = 8,
  parameter int GAP_H    = 32
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       start,
  input  logic       obj_sel,
  input  logic       erase,
  input  logic [6:0] bird_y,
  input  logic [7:0] wall_x,
  input  logic [6:0] gap_y,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy,
  output logic       finished_draw
);

  localparam logic [8:0] SCREEN_W9 = 9'(SCREEN_W);
  localparam logic [8:0] SCREEN_H9 = 9'(SCREEN_H);
  localparam logic [8:0] BIRD_X9   = 9'(BIRD_X);

  localparam logic [2:0] COLOUR_BG   = 3'b000;
  localparam logic [2:0] COLOUR_BIRD = 3'b110;
  localparam logic [2:0] COLOUR_WALL = 3'b010;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DRAW = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Snapshot of the request, taken when start is accepted
  logic       obj_sel_r;
  logic       erase_r;
  logic [6:0] bird_y_r;
  logic [7:0] wall_x_r;
  logic [6:0] gap_y_r;

  // Scan position inside the sprite
  logic [7:0] col_cnt;
  logic [7:0] row_cnt;

  logic       accept;
  logic [7:0] obj_w;
  logic [7:0] obj_h;
  logic       last_col;
  logic       last_pixel;

  logic [8:0] x_full;
  logic [8:0] y_full;
  logic [7:0] gap_end;
  logic       in_gap;
  logic       on_screen;

  assign accept = (state == IDLE) && start;

  // Sprite extent depends on which object was captured
  assign obj_w = obj_sel_r ? 8'(BIRD_W) : 8'(WALL_W);
  assign obj_h = obj_sel_r ? 8'(BIRD_H) : 8'(SCREEN_H);

  assign last_col   = (col_cnt == obj_w - 8'd1);
  assign last_pixel = last_col && (row_cnt == obj_h - 8'd1);

  // State register; reset drops straight back to IDLE, which also aborts
  // any draw in flight without a completion pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic plus the status outputs that depend only on state.
  // DONE always lasts exactly one cycle, so finished_draw is a single pulse
  // and any start seen there is dropped rather than queued.
  always_comb begin
    state_next    = state;
    busy          = 1'b0;
    finished_draw = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = DRAW;
        end
      end
      DRAW: begin
        busy = 1'b1;
        if (last_pixel) begin
          state_next = DONE;
        end
      end
      DONE: begin
        busy          = 1'b1;
        finished_draw = 1'b1;
        state_next    = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Capture the request on an accepted start so the caller is free to
  // change its inputs while the draw runs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      obj_sel_r <= 1'b0;
      erase_r   <= 1'b0;
      bird_y_r  <= 7'd0;
      wall_x_r  <= 8'd0;
      gap_y_r   <= 7'd0;
    end else if (accept) begin
      obj_sel_r <= obj_sel;
      erase_r   <= erase;
      bird_y_r  <= bird_y;
      wall_x_r  <= wall_x;
      gap_y_r   <= gap_y;
    end
  end

  // Row-major scan counters. They are cleared on entry to DRAW and again
  // after the final pixel, so they never wrap part-way through a sprite.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      col_cnt <= 8'd0;
      row_cnt <= 8'd0;
    end else if (accept) begin
      col_cnt <= 8'd0;
      row_cnt <= 8'd0;
    end else if (state == DRAW) begin
      if (last_pixel) begin
        col_cnt <= 8'd0;
        row_cnt <= 8'd0;
      end else if (last_col) begin
        col_cnt <= 8'd0;
        row_cnt <= row_cnt + 8'd1;
      end else begin
        col_cnt <= col_cnt + 8'd1;
      end
    end
  end

  // Screen coordinates are formed one bit wider than the outputs so that
  // positions past the screen edge can be recognised before truncation.
  assign x_full = (obj_sel_r ? BIRD_X9 : {1'b0, wall_x_r}) + {1'b0, col_cnt};
  assign y_full = (obj_sel_r ? {2'b00, bird_y_r} : 9'd0) + {1'b0, row_cnt};

  // Gap end is computed at 8 bits; a 7-bit gap start plus the gap height
  // cannot overflow it, so the gap never wraps to the top of the screen.
  assign gap_end = {1'b0, gap_y_r} + 8'(GAP_H);
  assign in_gap  = !obj_sel_r && (row_cnt >= {1'b0, gap_y_r}) && (row_cnt < gap_end);

  assign on_screen = (x_full < SCREEN_W9) && (y_full < SCREEN_H9);

  // Pixel outputs. Outside DRAW everything is held at zero so the adapter
  // never sees a stray write; inside DRAW x/y carry the truncated position
  // even when the pixel is clipped or lies in the gap.
  always_comb begin
    x      = 8'd0;
    y      = 7'd0;
    colour = 3'b000;
    plot   = 1'b0;
    if (state == DRAW) begin
      x    = x_full[7:0];
      y    = y_full[6:0];
      plot = on_screen && !in_gap;
      if (erase_r) begin
        colour = COLOUR_BG;
      end else if (obj_sel_r) begin
        colour = COLOUR_BIRD;
      end else begin
        colour = COLOUR_WALL;
      end
    end
  end

endmodule

// File: tb/tb_sprite_drawer.sv
// ----------------------------------------------------------------------------
// tb_sprite_drawer
//
// Directed bench for sprite_drawer: reset values, bird and wall draws, wall
// gap, edge clipping, erase colour, start ignored while busy, asynchronous
// reset during a draw, and input changes during a draw.
// ----------------------------------------------------------------------------
module tb_sprite_drawer;

  logic       clk;
  logic       resetn;
  logic       start;
  logic       obj_sel;
  logic       erase;
  logic [6:0] bird_y;
  logic [7:0] wall_x;
  logic [6:0] gap_y;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       finished_draw;

  int n_checks;
  int n_fail;
  int plotted;
  int bad;
  int fin_seen;

  sprite_drawer dut (
    .clk           (clk),
    .resetn        (resetn),
    .start         (start),
    .obj_sel       (obj_sel),
    .erase         (erase),
    .bird_y        (bird_y),
    .wall_x        (wall_x),
    .gap_y         (gap_y),
    .x             (x),
    .y             (y),
    .colour        (colour),
    .plot          (plot),
    .busy          (busy),
    .finished_draw (finished_draw)
  );

  // 10-time-unit clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Move to 1 time unit after the next rising edge
  task tick;
    @(posedge clk);
    #1;
  endtask

  // One counted comparison
  task checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected)
    else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Set request inputs and pulse start for one edge; returns in DRAW cycle 1
  task applyStimulus(input logic sel, input logic er, input logic [6:0] by,
                     input logic [7:0] wx, input logic [6:0] gy);
    obj_sel = sel;
    erase   = er;
    bird_y  = by;
    wall_x  = wx;
    gap_y   = gy;
    start   = 1'b1;
    tick();
    start   = 1'b0;
  endtask

  // Walk every DRAW cycle comparing against a reference scan. Returns the
  // number of plotted cycles and the number of cycles that disagreed.
  // poke_cycle pulses start for one cycle; change_cycle moves bird_y to 90.
  task scanDraw(input bit is_bird, input int bx, input int by, input int gy,
                input logic [2:0] exp_col, input int poke_cycle, input int change_cycle,
                output int n_plot, output int n_bad);
    int w;
    int h;
    int ex;
    int ey;
    int row;
    bit ep;
    w = is_bird ? 4 : 8;
    h = is_bird ? 4 : 120;
    n_plot = 0;
    n_bad  = 0;
    for (int i = 0; i < w * h; i++) begin
      row = i / w;
      ex  = bx + (i % w);
      ey  = by + row;
      ep  = (ex < 160) && (ey < 120) && !(!is_bird && row >= gy && row < gy + 32);
      if (plot) n_plot++;
      if (x !== 8'(ex) || y !== 7'(ey) || plot !== ep || colour !== exp_col ||
          busy !== 1'b1 || finished_draw !== 1'b0) begin
        if (n_bad < 4)
          $display("[TB] cycle %0d x=%0d y=%0d plot=%0b colour=%0d busy=%0b fin=%0b exp x=%0d y=%0d plot=%0b",
                   i, x, y, plot, colour, busy, finished_draw, ex & 255, ey & 127, ep);
        n_bad++;
      end
      if (i == poke_cycle) start = 1'b1;
      if (i == poke_cycle + 1) start = 1'b0;
      if (i == change_cycle) bird_y = 7'd90;
      tick();
    end
    start = 1'b0;
  endtask

  // In the DONE cycle: check the pulse, then the return to IDLE
  task checkDone(input string tag, input bit poke);
    checkOutput({tag, "_done_fin"}, 32'(finished_draw), 32'd1);
    checkOutput({tag, "_done_busy"}, 32'(busy), 32'd1);
    checkOutput({tag, "_done_plot"}, 32'(plot), 32'd0);
    if (poke) start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput({tag, "_idle_fin"}, 32'(finished_draw), 32'd0);
    checkOutput({tag, "_idle_busy"}, 32'(busy), 32'd0);
    tick();
    checkOutput({tag, "_idle2_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    resetn   = 1'b0;
    start    = 1'b0;
    obj_sel  = 1'b0;
    erase    = 1'b0;
    bird_y   = 7'd0;
    wall_x   = 8'd0;
    gap_y    = 7'd0;

    // Reset state
    tick();
    checkOutput("rst_x", 32'(x), 32'd0);
    checkOutput("rst_y", 32'(y), 32'd0);
    checkOutput("rst_colour", 32'(colour), 32'd0);
    checkOutput("rst_plot", 32'(plot), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_fin", 32'(finished_draw), 32'd0);
    resetn = 1'b1;
    tick();
    checkOutput("idle_busy", 32'(busy), 32'd0);

    // Bird draw at row 50
    $display("[TB] bird draw");
    applyStimulus(1'b1, 1'b0, 7'd50, 8'd0, 7'd0);
    checkOutput("bird_first_x", 32'(x), 32'd20);
    checkOutput("bird_first_y", 32'(y), 32'd50);
    scanDraw(1'b1, 20, 50, 0, 3'b110, -1, -1, plotted, bad);
    checkOutput("bird_bad", 32'(bad), 32'd0);
    checkOutput("bird_plotted", 32'(plotted), 32'd16);
    checkDone("bird", 1'b0);

    // Wall draw with gap rows 40..71
    $display("[TB] wall draw");
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd100, 7'd40);
    scanDraw(1'b0, 100, 0, 40, 3'b010, -1, -1, plotted, bad);
    checkOutput("wall_bad", 32'(bad), 32'd0);
    checkOutput("wall_plotted", 32'(plotted), 32'd704);
    checkDone("wall", 1'b0);

    // Wall at the right edge, gap rows 100..131 (only 100..119 on screen)
    $display("[TB] wall clip");
    applyStimulus(1'b0, 1'b0, 7'd0, 8'd156, 7'd100);
    scanDraw(1'b0, 156, 0, 100, 3'b010, -1, -1, plotted, bad);
    checkOutput("wclip_bad", 32'(bad), 32'd0);
    checkOutput("wclip_plotted", 32'(plotted), 32'd400);
    checkDone("wclip", 1'b0);

    // Bird at the bottom edge: rows 118,119 plotted, 120,121 clipped
    $display("[TB] bird clip");
    applyStimulus(1'b1, 1'b0, 7'd118, 8'd0, 7'd0);
    scanDraw(1'b1, 20, 118, 0, 3'b110, -1, -1, plotted, bad);
    checkOutput("bclip_bad", 32'(bad), 32'd0);
    checkOutput("bclip_plotted", 32'(plotted), 32'd8);
    checkDone("bclip", 1'b0);

    // Erase draw with start pulses during DRAW and DONE
    $display("[TB] erase with ignored starts");
    applyStimulus(1'b1, 1'b1, 7'd50, 8'd0, 7'd0);
    scanDraw(1'b1, 20, 50, 0, 3'b000, 3, -1, plotted, bad);
    checkOutput("erase_bad", 32'(bad), 32'd0);
    checkOutput("erase_plotted", 32'(plotted), 32'd16);
    checkDone("erase", 1'b1);

    // Asynchronous reset in DRAW cycle 5
    $display("[TB] async reset mid-draw");
    applyStimulus(1'b1, 1'b0, 7'd50, 8'd0, 7'd0);
    tick();
    tick();
    tick();
    tick();
    checkOutput("ar_pre_x", 32'(x), 32'd20);
    checkOutput("ar_pre_y", 32'(y), 32'd51);
    #2;
    resetn = 1'b0;
    #1;
    checkOutput("ar_plot", 32'(plot), 32'd0);
    checkOutput("ar_busy", 32'(busy), 32'd0);
    checkOutput("ar_x", 32'(x), 32'd0);
    fin_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (finished_draw !== 1'b0 || busy !== 1'b0) fin_seen++;
    end
    resetn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (finished_draw !== 1'b0 || busy !== 1'b0) fin_seen++;
    end
    checkOutput("ar_no_fin", 32'(fin_seen), 32'd0);
    applyStimulus(1'b1, 1'b0, 7'd50, 8'd0, 7'd0);
    scanDraw(1'b1, 20, 50, 0, 3'b110, -1, -1, plotted, bad);
    checkOutput("ar_redraw_bad", 32'(bad), 32'd0);
    checkOutput("ar_redraw_plotted", 32'(plotted), 32'd16);
    checkDone("ar_redraw", 1'b0);

    // bird_y changed to 90 during DRAW cycle 2 must not move the bird
    $display("[TB] input change mid-draw");
    applyStimulus(1'b1, 1'b0, 7'd50, 8'd0, 7'd0);
    scanDraw(1'b1, 20, 50, 0, 3'b110, -1, 1, plotted, bad);
    checkOutput("chg_bad", 32'(bad), 32'd0);
    checkOutput("chg_plotted", 32'(plotted), 32'd16);
    checkDone("chg", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
